cpu_load_controller: RTL and testbench

Sequencer that owns the external ports of the cpu top level. It streams a program into instruction memory and an initial image into data memory, then raises the cpu enable for a programmed number of cycles. After the run it reads back a window of data memory as an output stream. It sits between the test/host interface and the cpu, and is the only driver of addr_ext, wen_ext, wdata_ext, addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2 and enable.

---
 rtl/cpu_load_controller.sv | 207 ++++++++++++++++++++
 tb/tb_cpu_load_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_load_controller.sv
// cpu_load_controller
//   Owns the cpu top-level external ports. Streams a program into instruction
//   memory, an initial image into data memory, holds the cpu enable for a
//   programmed number of cycles, then reads a window of data memory back out.
//
//   Optional: LOADCTL_CHECKSUM_EN adds load_checksum, a rotate-xor digest of
//   every accepted load word.
//
// Ports
//   clk, arst_n                   clock, async active-low reset
//   start                         begin a session (only honoured in IDLE/DONE)
//   imem_words/dmem_words         load counts (clamped to memory capacity)
//   run_cycles                    cycles enable is held high
//   dump_words                    data words to read back (clamped)
//   load_valid/load_ready/load_data   load stream
//   dump_valid/dump_ready/dump_data   dump stream
//   addr_ext/wen_ext/wdata_ext        instruction memory write port
//   addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2/rdata_ext_2  data memory port
//   enable, busy, done            cpu enable and session status
module cpu_load_controller #(
  parameter int IMEM_WORDS_MAX = 512,
  parameter int DMEM_WORDS_MAX = 1024,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [9:0]       imem_words,
  input  logic [10:0]      dmem_words,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic [10:0]      dump_words,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [63:0]      load_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [63:0]      dump_data,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic [31:0]      wdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  input  logic [63:0]      rdata_ext_2,
  output logic             enable,
  output logic             busy,
  output logic             done
`ifdef LOADCTL_CHECKSUM_EN
  ,
  output logic [63:0]      load_checksum
`endif
);

  typedef enum logic [2:0] {
    IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [11:0]      imem_q, imem_d, dmem_q, dmem_d, dump_q, dump_d;
  logic [11:0]      idx_q, idx_d;
  logic [CNT_W-1:0] run_q, run_d, rctr_q, rctr_d;
  logic             wen_q, wen2_q;
  logic [63:0]      addr_q, addr2_q, wdata2_q, dump_data_q;
  logic [31:0]      wdata_q;
  logic             accept, start_acc;
  logic [11:0]      ci, cd, cu;

  function automatic logic [11:0] clamp(input logic [11:0] v, input int unsigned m);
    return (v > 12'(m)) ? 12'(m) : v;
  endfunction

  // First phase with work to do, in session order.
  function automatic state_t first_phase(input logic [11:0] i, input logic [11:0] d,
                                         input logic r, input logic [11:0] u);
    if (i != 12'd0)      return LOAD_I;
    else if (d != 12'd0) return LOAD_D;
    else if (r)          return RUN;
    else if (u != 12'd0) return DUMP_RD;
    else                 return DONE;
  endfunction

  assign ci = clamp({2'b00, imem_words}, IMEM_WORDS_MAX);
  assign cd = clamp({1'b0, dmem_words}, DMEM_WORDS_MAX);
  assign cu = clamp({1'b0, dump_words}, DMEM_WORDS_MAX);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    imem_d     = imem_q;
    dmem_d     = dmem_q;
    dump_d     = dump_q;
    run_d      = run_q;
    rctr_d     = rctr_q;
    start_acc  = 1'b0;
    load_ready = (state_q == LOAD_I) || (state_q == LOAD_D);
    accept     = load_valid && load_ready;
    // The trailing write pulse of a load phase may land in the next state;
    // hold off the read / the cpu enable for that cycle so the ports stay quiet.
    ren_ext_2  = (state_q == DUMP_RD) && !wen2_q;
    enable     = (state_q == RUN) && !wen_q && !wen2_q;
    dump_valid = (state_q == DUMP_OUT);
    busy       = (state_q != IDLE) && (state_q != DONE);
    done       = (state_q == DONE);
    case (state_q)
      IDLE, DONE: if (start) begin
        start_acc = 1'b1;
        imem_d    = ci;
        dmem_d    = cd;
        dump_d    = cu;
        run_d     = run_cycles;
        rctr_d    = run_cycles;
        idx_d     = 12'd0;
        state_d   = first_phase(ci, cd, run_cycles != '0, cu);
      end
      LOAD_I: if (accept) begin
        if (idx_q + 12'd1 == imem_q) begin
          idx_d   = 12'd0;
          state_d = first_phase(12'd0, dmem_q, run_q != '0, dump_q);
        end else idx_d = idx_q + 12'd1;
      end
      LOAD_D: if (accept) begin
        if (idx_q + 12'd1 == dmem_q) begin
          idx_d   = 12'd0;
          state_d = first_phase(12'd0, 12'd0, run_q != '0, dump_q);
        end else idx_d = idx_q + 12'd1;
      end
      RUN: if (enable) begin
        if (rctr_q == CNT_W'(1)) state_d = (dump_q != 12'd0) ? DUMP_RD : DONE;
        else                     rctr_d  = rctr_q - CNT_W'(1);
      end
      DUMP_RD:  if (ren_ext_2) state_d = DUMP_CAP;
      DUMP_CAP: state_d = DUMP_OUT;
      DUMP_OUT: if (dump_ready) begin
        if (idx_q + 12'd1 == dump_q) begin
          idx_d   = 12'd0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 12'd1;
          state_d = DUMP_RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      imem_q      <= '0;
      dmem_q      <= '0;
      dump_q      <= '0;
      run_q       <= '0;
      rctr_q      <= '0;
      wen_q       <= 1'b0;
      wen2_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      addr2_q     <= '0;
      wdata2_q    <= '0;
      dump_data_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      imem_q  <= imem_d;
      dmem_q  <= dmem_d;
      dump_q  <= dump_d;
      run_q   <= run_d;
      rctr_q  <= rctr_d;
      wen_q   <= accept && (state_q == LOAD_I);
      wen2_q  <= accept && (state_q == LOAD_D);
      if (accept && (state_q == LOAD_I)) begin
        addr_q  <= {50'd0, idx_q, 2'b00};
        wdata_q <= load_data[31:0];
      end
      if (accept && (state_q == LOAD_D)) begin
        addr2_q  <= {49'd0, idx_q, 3'b000};
        wdata2_q <= load_data;
      end else if (ren_ext_2) begin
        addr2_q  <= {49'd0, idx_q, 3'b000};
      end
      if (state_q == DUMP_CAP) dump_data_q <= rdata_ext_2;
    end
  end

  assign wen_ext     = wen_q;
  assign addr_ext    = addr_q;
  assign wdata_ext   = wdata_q;
  assign wen_ext_2   = wen2_q;
  assign wdata_ext_2 = wdata2_q;
  // Read address must be on the port in the read cycle itself.
  assign addr_ext_2  = ren_ext_2 ? {49'd0, idx_q, 3'b000} : addr2_q;
  assign dump_data   = dump_data_q;

`ifdef LOADCTL_CHECKSUM_EN
  logic [63:0] cs_q, cs_w;
  assign cs_w = (state_q == LOAD_I) ? {32'd0, load_data[31:0]} : load_data;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)        cs_q <= '0;
    else if (start_acc) cs_q <= '0;
    else if (accept)    cs_q <= {cs_q[62:0], cs_q[63]} ^ cs_w;
  end
  assign load_checksum = cs_q;
`endif

endmodule

// File: tb/tb_cpu_load_controller.sv
// Bench for cpu_load_controller: directed sessions with randomized words,
// gaps and dump back-pressure, checked against a word-list / memory model.
module tb_cpu_load_controller;
  logic        clk = 1'b0, arst_n = 1'b0, start = 1'b0;
  logic [9:0]  imem_words = '0;
  logic [10:0] dmem_words = '0, dump_words = '0;
  logic [31:0] run_cycles = '0;
  logic        load_valid = 1'b0, load_ready, dump_valid, dump_ready = 1'b0;
  logic [63:0] load_data = '0, dump_data, addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic        wen_ext, wen_ext_2, ren_ext_2, enable, busy, done;
  logic [31:0] wdata_ext;
`ifdef LOADCTL_CHECKSUM_EN
  logic [63:0] load_checksum;
`endif

  cpu_load_controller dut (
    .clk(clk), .arst_n(arst_n), .start(start), .imem_words(imem_words),
    .dmem_words(dmem_words), .run_cycles(run_cycles), .dump_words(dump_words),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2), .enable(enable),
    .busy(busy), .done(done)
`ifdef LOADCTL_CHECKSUM_EN
    , .load_checksum(load_checksum)
`endif
  );

  always #5 clk = ~clk;

  // data memory behind the external port: read data the cycle after ren
  logic [63:0] emem [0:1023];
  always @(posedge clk) begin
    if (wen_ext_2) emem[addr_ext_2[12:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= emem[addr_ext_2[12:3]];
  end

  // port monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [63:0] iw_a[$], iw_d[$], dw_a[$], dw_d[$], rd_a[$], dq[$];
  int iw_c[$];
  int en_cnt = 0, en_rise = 0, busy_cnt = 0, viol = 0;
  int last_wen_cyc = 0, last_acc_cyc = 0, done_rise_cyc = 0;
  logic prev_en = 0, prev_done = 0, prev_v = 0, prev_hs = 0;
  logic [63:0] prev_d = '0;
  always @(negedge clk) begin
    if (wen_ext) begin
      iw_a.push_back(addr_ext); iw_d.push_back({32'd0, wdata_ext}); iw_c.push_back(cyc);
      last_wen_cyc <= cyc;
    end
    if (wen_ext_2) begin dw_a.push_back(addr_ext_2); dw_d.push_back(wdata_ext_2); end
    if (ren_ext_2) rd_a.push_back(addr_ext_2);
    if (dump_valid && dump_ready) dq.push_back(dump_data);
    if (load_valid && load_ready) last_acc_cyc <= cyc;
    if (enable) en_cnt <= en_cnt + 1;
    if (enable && !prev_en) en_rise <= en_rise + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (done && !prev_done) done_rise_cyc <= cyc;
    if ((enable && (load_ready || wen_ext || wen_ext_2 || ren_ext_2)) ||
        (wen_ext_2 && ren_ext_2) || (done && busy) ||
        (prev_v && !prev_hs && (!dump_valid || dump_data !== prev_d)))
      viol <= viol + 1;
    prev_en <= enable; prev_done <= done; prev_v <= dump_valid;
    prev_hs <= dump_valid && dump_ready; prev_d <= dump_data;
  end

  int n_chk = 0, n_fail = 0;
  logic [63:0] words[$];
  logic [63:0] ref_mem [0:1023];
  int s_ib, s_busy;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, o, e);
    end
  endtask

  task automatic zero_chk(input string p);
    chk({p, "_enable"}, 64'(enable), 0);   chk({p, "_busy"}, 64'(busy), 0);
    chk({p, "_done"}, 64'(done), 0);       chk({p, "_ready"}, 64'(load_ready), 0);
    chk({p, "_dvalid"}, 64'(dump_valid), 0); chk({p, "_wen"}, 64'(wen_ext), 0);
    chk({p, "_wen2"}, 64'(wen_ext_2), 0);  chk({p, "_ren2"}, 64'(ren_ext_2), 0);
    chk({p, "_addr"}, addr_ext, 0);        chk({p, "_addr2"}, addr_ext_2, 0);
    chk({p, "_wdata"}, 64'(wdata_ext), 0); chk({p, "_wdata2"}, wdata_ext_2, 0);
    chk({p, "_ddata"}, dump_data, 0);
  endtask

  // One full session; words may be pre-filled by the caller (directed data).
  // gap < 0 toggles load_valid every cycle, else gap is the idle percentage.
  task automatic session(input int ni, input int nd, input logic [31:0] nr, input int nu,
                         input int gap, input int hmin, input int hmax);
    int ci, cd, cu, wp, n, hold, vcnt, bad, ib, db, rb, ob, eb, er, bb, vb;
    logic acc, hs, pv;
    logic [63:0] cs;
    ci = (ni > 512) ? 512 : ni;
    cd = (nd > 1024) ? 1024 : nd;
    cu = (nu > 1024) ? 1024 : nu;
    while (words.size() < ci + cd + 4) words.push_back({$urandom, $urandom});
    ib = iw_a.size(); db = dw_a.size(); rb = rd_a.size(); ob = dq.size();
    eb = en_cnt; er = en_rise; bb = busy_cnt; vb = viol;
    imem_words = 10'(ni); dmem_words = 11'(nd); run_cycles = nr; dump_words = 11'(nu);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wp = 0; vcnt = 0; hold = $urandom_range(hmax, hmin);
    for (n = 0; n < 12000; n++) begin
      if (gap < 0) load_valid = (wp < words.size()) && !n[0];
      else         load_valid = (wp < words.size()) && ($urandom_range(99) >= gap);
      load_data  = (wp < words.size()) ? words[wp] : 64'd0;
      dump_ready = dump_valid && (vcnt >= hold);
      @(negedge clk);
      acc = load_valid && load_ready; hs = dump_valid && dump_ready; pv = dump_valid;
      if (done) break;
      @(posedge clk); #1;
      if (acc) wp++;
      if (hs) begin vcnt = 0; hold = $urandom_range(hmax, hmin); end
      else if (pv) vcnt++;
    end
    chk("session_done", 64'(n < 12000), 1);
    load_valid = 1'b0; dump_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("consumed", 64'(wp), 64'(ci + cd));
    chk("imem_wr_cnt", 64'(iw_a.size() - ib), 64'(ci));
    bad = 0;
    for (int k = 0; k < ci && ib + k < iw_a.size(); k++)
      if (iw_a[ib + k] !== 64'(4 * k) || iw_d[ib + k] !== {32'd0, words[k][31:0]}) bad++;
    chk("imem_wr_bad", 64'(bad), 0);
    for (int k = 0; k < cd; k++) ref_mem[k] = words[ci + k];
    chk("dmem_wr_cnt", 64'(dw_a.size() - db), 64'(cd));
    bad = 0;
    for (int k = 0; k < cd && db + k < dw_a.size(); k++)
      if (dw_a[db + k] !== 64'(8 * k) || dw_d[db + k] !== words[ci + k]) bad++;
    chk("dmem_wr_bad", 64'(bad), 0);
    chk("enable_cycles", 64'(en_cnt - eb), 64'(nr));
    chk("enable_runs", 64'(en_rise - er), 64'(nr != 0));
    chk("dump_rd_cnt", 64'(rd_a.size() - rb), 64'(cu));
    chk("dump_out_cnt", 64'(dq.size() - ob), 64'(cu));
    bad = 0;
    for (int k = 0; k < cu && rb + k < rd_a.size() && ob + k < dq.size(); k++)
      if (rd_a[rb + k] !== 64'(8 * k) || dq[ob + k] !== ref_mem[k]) bad++;
    chk("dump_bad", 64'(bad), 0);
    chk("protocol_viol", 64'(viol - vb), 0);
    chk("done_end", 64'(done), 1);
`ifdef LOADCTL_CHECKSUM_EN
    cs = '0;
    for (int k = 0; k < ci + cd; k++)
      cs = {cs[62:0], cs[63]} ^ ((k < ci) ? {32'd0, words[k][31:0]} : words[k]);
    chk("checksum", load_checksum, cs);
`endif
    s_ib = ib; s_busy = busy_cnt - bb;
    words.delete();
  endtask

  initial begin
    int eb, n;
    #1;
    zero_chk("reset");
    repeat (2) @(negedge clk);
    arst_n = 1'b1;

    // three instruction words, valid held high
    words = '{64'h13, 64'h93, 64'h113};
    session(3, 0, 0, 0, 0, 0, 0);
    chk("t1_back_to_back", 64'(iw_c[s_ib + 2] - iw_c[s_ib]), 2);
    chk("t1_done_after_acc", 64'(done_rise_cyc), 64'(last_acc_cyc + 1));
    chk("t1_last_wen_vs_done", 64'(last_wen_cyc), 64'(done_rise_cyc));

    // two data words with load_valid toggling
    words = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
    session(0, 2, 0, 0, -1, 0, 0);

    // fill all of data memory (count clamped from 2000)
    session(0, 2000, 0, 0, 30, 0, 0);
    chk("fill_last_addr", dw_a[dw_a.size() - 1], 64'd8184);

    // run only
    session(0, 0, 5, 0, 0, 0, 0);
    chk("run_busy_cycles", 64'(s_busy), 5);

    // dump with 4 cycles of back-pressure per word
    words = '{64'h11, 64'h22};
    session(0, 2, 0, 2, 0, 4, 4);

    // reset in the middle of a run
    imem_words = '0; dmem_words = '0; dump_words = '0; run_cycles = 10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    eb = en_cnt;
    for (n = 0; n < 50 && en_cnt - eb < 3; n++) begin @(posedge clk); #1; end
    chk("mid_rst_reached", 64'(en_cnt - eb), 3);
    chk("mid_rst_pre_en", 64'(enable), 1);
    #2 arst_n = 1'b0;
    #1 zero_chk("mid_rst");
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 64'(done), 0);
    session(2, 1, 3, 1, 20, 0, 2);

    // instruction count clamp
    session(600, 0, 0, 0, 0, 0, 0);
    chk("imem_last_addr", iw_a[iw_a.size() - 1], 64'd2044);

    // mixed random sessions
    for (int r = 0; r < 6; r++)
      session($urandom_range(12), $urandom_range(12), $urandom_range(15),
              $urandom_range(30), 40, 0, 3);

    // full dump, count clamped from 1500
    session(0, 0, 0, 1500, 0, 0, 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
